// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: prioritised redirects, stall hold,
// and a direct-mapped BTB giving next-line prediction for the current PC.
module pc_gen #(
    parameter int                XLEN         = 32,
    parameter logic [XLEN-1:0]   RESET_VECTOR = '0,
    parameter int                INST_BYTES   = 4,
    parameter int                BTB_ENTRIES  = 8,
    parameter int                NUM_REDIR    = 3
) (
    input  logic                      clk,
    input  logic                      rst_async,
    input  logic                      stall_n,
    input  logic [NUM_REDIR-1:0]      redir_en,
    input  logic [NUM_REDIR*XLEN-1:0] redir_addr,
    input  logic                      btb_upd_en,
    input  logic [XLEN-1:0]           btb_upd_pc,
    input  logic [XLEN-1:0]           btb_upd_target,
    input  logic                      btb_upd_taken,
    output logic [XLEN-1:0]           pc,
    output logic                      pc_valid,
    output logic                      pred_taken
);

    localparam int OFF  = $clog2(INST_BYTES);
    localparam int IDX  = $clog2(BTB_ENTRIES);
    localparam int TAGW = XLEN - OFF - IDX;
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INST_BYTES) - XLEN'(1));

    logic [XLEN-1:0] r_pc;
    logic            r_pc_valid;
    logic [XLEN-1:0] w_pc_next;

    logic            r_btb_valid  [BTB_ENTRIES];
    logic [TAGW-1:0] r_btb_tag    [BTB_ENTRIES];
    logic [XLEN-1:0] r_btb_target [BTB_ENTRIES];

    logic [IDX-1:0]  w_lkp_idx;
    logic [TAGW-1:0] w_lkp_tag;
    logic            w_hit;
    logic [IDX-1:0]  w_upd_idx;
    logic [TAGW-1:0] w_upd_tag;

    logic            w_redir_any;
    logic [XLEN-1:0] w_redir_target;

    // Lookup on the current PC; reads the pre-update contents (no bypass).
    assign w_lkp_idx = r_pc[OFF+IDX-1:OFF];
    assign w_lkp_tag = r_pc[XLEN-1:OFF+IDX];
    assign w_hit     = r_btb_valid[w_lkp_idx] && (r_btb_tag[w_lkp_idx] == w_lkp_tag);

    assign w_upd_idx = btb_upd_pc[OFF+IDX-1:OFF];
    assign w_upd_tag = btb_upd_pc[XLEN-1:OFF+IDX];

    // Walk from the highest channel down so the lowest set index wins.
    always_comb begin
        w_redir_any    = |redir_en;
        w_redir_target = '0;
        for (int i = NUM_REDIR - 1; i >= 0; i--) begin
            if (redir_en[i]) begin
                w_redir_target = redir_addr[i*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        w_pc_next = r_pc + XLEN'(INST_BYTES);
        if (w_redir_any) begin
            w_pc_next = w_redir_target & ALIGN_MASK;
        end else if (!stall_n) begin
            w_pc_next = r_pc;
        end else if (w_hit) begin
            w_pc_next = r_btb_target[w_lkp_idx];
        end
    end

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            r_pc       <= RESET_VECTOR;
            r_pc_valid <= 1'b0;
        end else begin
            r_pc       <= w_pc_next;
            r_pc_valid <= 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < BTB_ENTRIES; gi++) begin : g_btb
            logic w_sel;
            assign w_sel = btb_upd_en && (w_upd_idx == IDX'(gi));

            always_ff @(posedge clk or posedge rst_async) begin
                if (rst_async) begin
                    r_btb_valid[gi] <= 1'b0;
                end else if (w_sel) begin
                    if (btb_upd_taken) begin
                        r_btb_valid[gi] <= 1'b1;
                    end else if (r_btb_tag[gi] == w_upd_tag) begin
                        r_btb_valid[gi] <= 1'b0;
                    end
                end
            end

            // Payload needs no reset: it is only observed through the valid bit.
            always_ff @(posedge clk) begin
                if (w_sel && btb_upd_taken) begin
                    r_btb_tag[gi]    <= w_upd_tag;
                    r_btb_target[gi] <= btb_upd_target & ALIGN_MASK;
                end
            end
        end
    endgenerate

    assign pc         = r_pc;
    assign pc_valid   = r_pc_valid;
    assign pred_taken = w_hit;

endmodule
